// File: rtl/axi_lite_regfile_if.sv
// rtl/axi_lite_regfile_if.sv - AXI4-Lite bus bundle between the interconnect slave port and the register file
interface axi_lite_regfile_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_lite_regfile.sv
// rtl/axi_lite_regfile.sv - AXI4-Lite slave register file with byte strobes and SLVERR outside its window
module axi_lite_regfile #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                           aclk,
    input  logic                           areset_n,
    axi_lite_regfile_if.slave              bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
    localparam int                    STRB_W = DATA_WIDTH / 8;
    localparam int                    IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] WIN    = ADDR_WIDTH'(NUM_REGS * 4);
    localparam logic [1:0]            OKAY   = 2'b00;
    localparam logic [1:0]            SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // write channel state
    w_state_t              w_state, w_state_d;
    logic                  aw_held, aw_held_d, w_held, w_held_d;
    logic                  awready_q, awready_d, wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;

    // read channel state
    r_state_t              r_state, r_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]     w_strb;
    logic [ADDR_WIDTH:0]   w_diff, r_diff;
    logic                  w_hit, r_hit;
    logic [IDX_W-1:0]      w_idx, r_idx;

    assign aw_hs  = bus.awvalid && awready_q;
    assign w_hs   = bus.wvalid && wready_q;
    assign ar_hs  = bus.arvalid && arready_q;

    // A beat arriving this cycle takes precedence over the (empty) holding register.
    assign w_addr = aw_hs ? bus.awaddr : awaddr_q;
    assign w_data = w_hs ? bus.wdata : wdata_q;
    assign w_strb = w_hs ? bus.wstrb : wstrb_q;
    assign commit = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

    // The extra top bit is the borrow: set when the address lies below the base.
    assign w_diff = {1'b0, w_addr} - {1'b0, BASE_ADDR};
    assign r_diff = {1'b0, bus.araddr} - {1'b0, BASE_ADDR};
    assign w_hit  = !w_diff[ADDR_WIDTH] && (w_diff[ADDR_WIDTH-1:0] < WIN);
    assign r_hit  = !r_diff[ADDR_WIDTH] && (r_diff[ADDR_WIDTH-1:0] < WIN);
    assign w_idx  = w_diff[IDX_W+1:2];
    assign r_idx  = r_diff[IDX_W+1:2];

    always_comb begin
        w_state_d = w_state;
        aw_held_d = aw_held;
        w_held_d  = w_held;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        case (w_state)
            W_IDLE: begin
                if (commit) begin
                    w_state_d = W_RESP;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = w_hit ? OKAY : SLVERR;
                end else begin
                    if (aw_hs) aw_held_d = 1'b1;
                    if (w_hs)  w_held_d  = 1'b1;
                end
            end
            W_RESP: begin
                if (bus.bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                end
            end
        endcase
        awready_d = (w_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (w_state_d == W_IDLE) && !w_held_d;
    end

    always_comb begin
        r_state_d = r_state;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (r_state)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    rvalid_d  = 1'b1;
                    rdata_d   = r_hit ? regs[r_idx] : '0;
                    rresp_d   = r_hit ? OKAY : SLVERR;
                end
            end
            R_DATA: begin
                if (bus.rready) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                end
            end
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            w_state   <= W_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            w_state   <= w_state_d;
            aw_held   <= aw_held_d;
            w_held    <= w_held_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state   <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            if (aw_hs) awaddr_q <= bus.awaddr;
            if (w_hs) begin
                wdata_q <= bus.wdata;
                wstrb_q <= bus.wstrb;
            end
            if (commit && w_hit) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (w_strb[b]) regs[w_idx][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_export
        assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = rdata_q;
endmodule

// File: tb/tb_axi_lite_regfile.sv
// tb/tb_axi_lite_regfile.sv - randomized bench: two register files (base 0x0 and 0x10) driven in lockstep
module tb_axi_lite_regfile;
    logic         aclk = 1'b0;
    logic         areset_n = 1'b0;
    logic [127:0] regs_a, regs_b;
    int           total = 0;
    int           bad = 0;

    logic [31:0] ma [4];
    logic [31:0] mb [4];

    always #5 aclk = ~aclk;

    axi_lite_regfile_if bus_a ();
    axi_lite_regfile_if bus_b ();

    assign bus_b.araddr  = bus_a.araddr;
    assign bus_b.arvalid = bus_a.arvalid;
    assign bus_b.rready  = bus_a.rready;
    assign bus_b.awaddr  = bus_a.awaddr;
    assign bus_b.awvalid = bus_a.awvalid;
    assign bus_b.wdata   = bus_a.wdata;
    assign bus_b.wstrb   = bus_a.wstrb;
    assign bus_b.wvalid  = bus_a.wvalid;
    assign bus_b.bready  = bus_a.bready;

    axi_lite_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(4), .BASE_ADDR(32'h0)) dut_a (
        .aclk(aclk), .areset_n(areset_n), .bus(bus_a.slave), .regs_o(regs_a)
    );
    axi_lite_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(4), .BASE_ADDR(32'h10)) dut_b (
        .aclk(aclk), .areset_n(areset_n), .bus(bus_b.slave), .regs_o(regs_b)
    );

    function automatic bit m_hit(input bit sel, input logic [31:0] addr);
        logic [31:0] base = sel ? 32'h10 : 32'h0;
        return (addr >= base) && (addr - base < 32'd16);
    endfunction

    function automatic int m_idx(input bit sel, input logic [31:0] addr);
        logic [31:0] base = sel ? 32'h10 : 32'h0;
        return int'((addr - base) / 4);
    endfunction

    function automatic logic [31:0] m_get(input bit sel, input logic [31:0] addr);
        if (!m_hit(sel, addr)) return 32'h0;
        return sel ? mb[m_idx(sel, addr)] : ma[m_idx(sel, addr)];
    endfunction

    function automatic logic [1:0] m_resp(input bit sel, input logic [31:0] addr);
        return m_hit(sel, addr) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [127:0] m_regs(input bit sel);
        return sel ? {mb[3], mb[2], mb[1], mb[0]} : {ma[3], ma[2], ma[1], ma[0]};
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        for (int s = 0; s < 2; s++) begin
            if (m_hit(s[0], addr)) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) begin
                        if (s == 0) ma[m_idx(1'b0, addr)][8*b +: 8] = data[8*b +: 8];
                        else        mb[m_idx(1'b1, addr)][8*b +: 8] = data[8*b +: 8];
                    end
                end
            end
        end
    endtask

    task automatic model_clear;
        for (int i = 0; i < 4; i++) begin
            ma[i] = 32'h0;
            mb[i] = 32'h0;
        end
    endtask

    // order: 0 = AW and W together, 1 = W first, 2 = AW first; gap = cycles between the two handshakes
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int order, input int gap, input string tag);
        int n;
        logic [1:0] ea = m_resp(1'b0, addr);
        logic [1:0] eb = m_resp(1'b1, addr);
        bus_a.awaddr = addr;
        bus_a.wdata  = data;
        bus_a.wstrb  = strb;
        bus_a.awvalid = (order != 1);
        bus_a.wvalid  = (order != 2);
        for (int phase = 0; phase < ((order == 0) ? 1 : 2); phase++) begin
            if (phase == 1) begin
                repeat (gap - 1) @(posedge aclk);
                #1;
                bus_a.awvalid = (order == 1);
                bus_a.wvalid  = (order == 2);
            end
            n = 0;
            while (!((!bus_a.awvalid || bus_a.awready) && (!bus_a.wvalid || bus_a.wready)) && n < 20) begin
                @(posedge aclk); #1; n++;
            end
            total++;
            if (n >= 20) begin bad++; $display("FAIL %s_ready_timeout phase=%0d", tag, phase); end
            @(posedge aclk); #1;
            bus_a.awvalid = 1'b0;
            bus_a.wvalid  = 1'b0;
            if (order != 0 && phase == 0) begin
                total++;
                if ({bus_a.bvalid, bus_b.bvalid} !== 2'b00) begin
                    bad++; $display("FAIL %s_early_bvalid got=%b want=00", tag, {bus_a.bvalid, bus_b.bvalid});
                end
            end
        end
        total++;
        if ({bus_a.bvalid, bus_b.bvalid} !== 2'b11) begin
            bad++; $display("FAIL %s_bvalid_latency got=%b want=11", tag, {bus_a.bvalid, bus_b.bvalid});
        end
        total++;
        if ({bus_a.bresp, bus_b.bresp} !== {ea, eb}) begin
            bad++; $display("FAIL %s_bresp got=%b want=%b", tag, {bus_a.bresp, bus_b.bresp}, {ea, eb});
        end
        model_write(addr, data, strb);
        bus_a.bready = 1'b1;
        @(posedge aclk); #1;
        bus_a.bready = 1'b0;
        total++;
        if ({bus_a.bvalid, bus_b.bvalid} !== 2'b00) begin
            bad++; $display("FAIL %s_bvalid_drop got=%b want=00", tag, {bus_a.bvalid, bus_b.bvalid});
        end
        total++;
        if ({regs_a, regs_b} !== {m_regs(1'b0), m_regs(1'b1)}) begin
            bad++; $display("FAIL %s_regs got=%h_%h want=%h_%h", tag, regs_a, regs_b, m_regs(1'b0), m_regs(1'b1));
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input string tag);
        int n = 0;
        logic [31:0] da = m_get(1'b0, addr);
        logic [31:0] db = m_get(1'b1, addr);
        logic [1:0]  ea = m_resp(1'b0, addr);
        logic [1:0]  eb = m_resp(1'b1, addr);
        bus_a.araddr  = addr;
        bus_a.arvalid = 1'b1;
        while (!bus_a.arready && n < 20) begin @(posedge aclk); #1; n++; end
        total++;
        if (n >= 20) begin bad++; $display("FAIL %s_arready_timeout", tag); end
        @(posedge aclk); #1;
        bus_a.arvalid = 1'b0;
        total++;
        if ({bus_a.rvalid, bus_b.rvalid} !== 2'b11) begin
            bad++; $display("FAIL %s_rvalid_latency got=%b want=11", tag, {bus_a.rvalid, bus_b.rvalid});
        end
        total++;
        if ({bus_a.rdata, bus_b.rdata} !== {da, db}) begin
            bad++; $display("FAIL %s_rdata got=%h_%h want=%h_%h", tag, bus_a.rdata, bus_b.rdata, da, db);
        end
        total++;
        if ({bus_a.rresp, bus_b.rresp} !== {ea, eb}) begin
            bad++; $display("FAIL %s_rresp got=%b want=%b", tag, {bus_a.rresp, bus_b.rresp}, {ea, eb});
        end
        bus_a.rready = 1'b1;
        @(posedge aclk); #1;
        bus_a.rready = 1'b0;
        total++;
        if ({bus_a.rvalid, bus_b.rvalid} !== 2'b00) begin
            bad++; $display("FAIL %s_rvalid_drop got=%b want=00", tag, {bus_a.rvalid, bus_b.rvalid});
        end
    endtask

    task automatic test_reset;
        areset_n = 1'b0;
        bus_a.araddr = '0; bus_a.arvalid = 1'b0; bus_a.rready = 1'b0;
        bus_a.awaddr = '0; bus_a.awvalid = 1'b0; bus_a.wdata = '0;
        bus_a.wstrb = '0;  bus_a.wvalid = 1'b0;  bus_a.bready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        total++;
        if ({bus_a.arready, bus_a.awready, bus_a.wready, bus_b.arready, bus_b.awready, bus_b.wready} !== 6'b0) begin
            bad++; $display("FAIL reset_ready got=%b want=0", {bus_a.arready, bus_a.awready, bus_a.wready});
        end
        total++;
        if ({bus_a.rvalid, bus_a.bvalid, bus_a.rresp, bus_a.bresp, bus_b.rvalid, bus_b.bvalid, bus_b.rresp, bus_b.bresp} !== 12'b0) begin
            bad++; $display("FAIL reset_resp got=%b want=0", {bus_a.rvalid, bus_a.bvalid, bus_a.rresp, bus_a.bresp});
        end
        total++;
        if ({bus_a.rdata, bus_b.rdata} !== 64'h0) begin
            bad++; $display("FAIL reset_rdata got=%h_%h want=0", bus_a.rdata, bus_b.rdata);
        end
        total++;
        if ({regs_a, regs_b} !== 256'h0) begin
            bad++; $display("FAIL reset_regs got=%h_%h want=0", regs_a, regs_b);
        end
        areset_n = 1'b1;
        model_clear();
        @(posedge aclk); #1;
        total++;
        if ({bus_a.arready, bus_a.awready, bus_a.wready, bus_b.arready, bus_b.awready, bus_b.wready} !== 6'b111111) begin
            bad++; $display("FAIL reset_release_ready got=%b want=111111",
                {bus_a.arready, bus_a.awready, bus_a.wready, bus_b.arready, bus_b.awready, bus_b.wready});
        end
    endtask

    task automatic test_read_all;
        for (int i = 0; i < 4; i++) do_read(32'(i * 4), "read_zero");
    endtask

    task automatic test_write_full;
        do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 1, "wr_full");
        do_read(32'h4, "rd_full");
        total++;
        if (regs_a[63:32] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL wr_full_export got=%h want=deadbeef", regs_a[63:32]);
        end
    endtask

    task automatic test_strobe;
        do_write(32'h8, 32'hAABBCCDD, 4'hF, 2, 3, "wr_prior");
        do_write(32'h8, 32'h11223344, 4'b0101, 1, 2, "wr_strobe");
        total++;
        if (regs_a[95:64] !== 32'hAA22CC44) begin
            bad++; $display("FAIL strobe_merge got=%h want=aa22cc44", regs_a[95:64]);
        end
        do_write(32'hA, 32'hFFFFFFFF, 4'h0, 0, 1, "wr_nostrb");
        do_read(32'hB, "rd_unaligned");
    endtask

    task automatic test_window;
        do_write(32'h20, 32'h12345678, 4'hF, 0, 1, "wr_oor");
        do_read(32'h0C, "rd_below_base");
        do_write(32'h14, 32'hCAFEF00D, 4'hF, 1, 1, "wr_base_b");
        do_read(32'h14, "rd_base_b");
    endtask

    task automatic test_stall;
        int n = 0;
        logic [31:0] exp_a, exp_b;
        bus_a.awaddr = 32'h4; bus_a.wdata = $urandom; bus_a.wstrb = 4'hF;
        bus_a.awvalid = 1'b1; bus_a.wvalid = 1'b1;
        bus_a.araddr = 32'h18; bus_a.arvalid = 1'b1;
        while (!(bus_a.awready && bus_a.wready && bus_a.arready) && n < 20) begin @(posedge aclk); #1; n++; end
        total++;
        if (n >= 20) begin bad++; $display("FAIL stall_ready_timeout"); end
        exp_a = m_get(1'b0, 32'h18);
        exp_b = m_get(1'b1, 32'h18);
        @(posedge aclk); #1;
        model_write(32'h4, bus_a.wdata, 4'hF);
        bus_a.awvalid = 1'b0; bus_a.wvalid = 1'b0;
        bus_a.araddr = 32'h1C;
        for (int c = 0; c < 5; c++) begin
            total++;
            if ({bus_a.bvalid, bus_b.bvalid, bus_a.rvalid, bus_b.rvalid, bus_a.bresp, bus_b.bresp, bus_a.rresp, bus_b.rresp}
                    !== {4'b1111, m_resp(1'b0, 32'h4), m_resp(1'b1, 32'h4), m_resp(1'b0, 32'h18), m_resp(1'b1, 32'h18)}) begin
                bad++; $display("FAIL stall_hold_resp cycle=%0d got=%b", c,
                    {bus_a.bvalid, bus_b.bvalid, bus_a.rvalid, bus_b.rvalid, bus_a.bresp, bus_b.bresp, bus_a.rresp, bus_b.rresp});
            end
            total++;
            if ({bus_a.rdata, bus_b.rdata} !== {exp_a, exp_b}) begin
                bad++; $display("FAIL stall_hold_rdata cycle=%0d got=%h_%h want=%h_%h", c, bus_a.rdata, bus_b.rdata, exp_a, exp_b);
            end
            total++;
            if ({bus_a.arready, bus_a.awready, bus_a.wready, bus_b.arready, bus_b.awready, bus_b.wready} !== 6'b0) begin
                bad++; $display("FAIL stall_ready cycle=%0d got=%b want=0", c, {bus_a.arready, bus_a.awready, bus_a.wready});
            end
            @(posedge aclk); #1;
        end
        bus_a.rready = 1'b1;
        @(posedge aclk); #1;
        bus_a.rready = 1'b0;
        total++;
        if ({bus_a.rvalid, bus_a.arready, bus_b.rvalid, bus_b.arready} !== 4'b0101) begin
            bad++; $display("FAIL stall_release got=%b want=0101", {bus_a.rvalid, bus_a.arready, bus_b.rvalid, bus_b.arready});
        end
        @(posedge aclk); #1;
        bus_a.arvalid = 1'b0;
        total++;
        if ({bus_a.rvalid, bus_b.rvalid, bus_a.rdata, bus_b.rdata} !== {2'b11, m_get(1'b0, 32'h1C), m_get(1'b1, 32'h1C)}) begin
            bad++; $display("FAIL stall_second_ar got=%b_%h_%h want=%h_%h", {bus_a.rvalid, bus_b.rvalid},
                bus_a.rdata, bus_b.rdata, m_get(1'b0, 32'h1C), m_get(1'b1, 32'h1C));
        end
        bus_a.rready = 1'b1; bus_a.bready = 1'b1;
        @(posedge aclk); #1;
        bus_a.rready = 1'b0; bus_a.bready = 1'b0;
        total++;
        if ({bus_a.bvalid, bus_b.bvalid, bus_a.rvalid, bus_b.rvalid} !== 4'b0) begin
            bad++; $display("FAIL stall_drain got=%b want=0", {bus_a.bvalid, bus_b.bvalid, bus_a.rvalid, bus_b.rvalid});
        end
    endtask

    task automatic test_collision;
        logic [31:0] exp_a, exp_b;
        do_write(32'h0, 32'h0, 4'hF, 0, 1, "col_init");
        exp_a = m_get(1'b0, 32'h0);
        exp_b = m_get(1'b1, 32'h0);
        bus_a.awaddr = 32'h0; bus_a.wdata = 32'h5; bus_a.wstrb = 4'hF;
        bus_a.awvalid = 1'b1; bus_a.wvalid = 1'b1;
        bus_a.araddr = 32'h0; bus_a.arvalid = 1'b1;
        @(posedge aclk); #1;
        bus_a.awvalid = 1'b0; bus_a.wvalid = 1'b0; bus_a.arvalid = 1'b0;
        model_write(32'h0, 32'h5, 4'hF);
        total++;
        if ({bus_a.rvalid, bus_b.rvalid, bus_a.bvalid, bus_b.bvalid, bus_a.rdata, bus_b.rdata} !== {4'hF, exp_a, exp_b}) begin
            bad++; $display("FAIL collision_old_value got=%b_%h_%h want=1111_%h_%h",
                {bus_a.rvalid, bus_b.rvalid, bus_a.bvalid, bus_b.bvalid}, bus_a.rdata, bus_b.rdata, exp_a, exp_b);
        end
        bus_a.rready = 1'b1; bus_a.bready = 1'b1;
        @(posedge aclk); #1;
        bus_a.rready = 1'b0; bus_a.bready = 1'b0;
        do_read(32'h0, "collision_new_value");
    endtask

    task automatic test_reset_mid;
        bus_a.awaddr = 32'h0; bus_a.wdata = $urandom | 32'h1; bus_a.wstrb = 4'hF;
        bus_a.awvalid = 1'b1; bus_a.wvalid = 1'b1;
        @(posedge aclk); #1;
        bus_a.awvalid = 1'b0; bus_a.wvalid = 1'b0;
        total++;
        if ({bus_a.bvalid, bus_b.bvalid} !== 2'b11) begin
            bad++; $display("FAIL rstmid_bvalid got=%b want=11", {bus_a.bvalid, bus_b.bvalid});
        end
        areset_n = 1'b0;
        @(posedge aclk); #1;
        total++;
        if ({bus_a.bvalid, bus_b.bvalid} !== 2'b00) begin
            bad++; $display("FAIL rstmid_bvalid_clear got=%b want=00", {bus_a.bvalid, bus_b.bvalid});
        end
        total++;
        if ({regs_a, regs_b} !== 256'h0) begin
            bad++; $display("FAIL rstmid_regs got=%h_%h want=0", regs_a, regs_b);
        end
        areset_n = 1'b1;
        model_clear();
        @(posedge aclk); #1;
        do_read(32'h0, "rstmid_read");
    endtask

    task automatic test_random;
        logic [31:0] addr;
        for (int i = 0; i < 30; i++) begin
            addr = 32'($urandom_range(0, 47));
            do_write(addr, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                     int'($urandom_range(1, 3)), "rnd_wr");
            addr = 32'($urandom_range(0, 47));
            do_read(addr, "rnd_rd");
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_all();
        test_write_full();
        test_strobe();
        test_window();
        test_stall();
        test_collision();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_lite_regfile.md
# axi_lite_regfile

AXI4-Lite slave register file that sits directly downstream of the AXI4-Lite interconnect, on one of its slave ports. It holds NUM_REGS 32-bit registers in one address window, accepts single-beat reads and writes with byte strobes, and returns SLVERR for addresses outside that window. Register contents are also exported in parallel for use by other logic and for bench checking.

## Interface
- ADDR_WIDTH, 32, width of araddr/awaddr.
- DATA_WIDTH, 32, data width; only 32 is supported.
- NUM_REGS, 4, number of registers; the window is NUM_REGS*4 bytes (0x10 matches one interconnect slot).
- BASE_ADDR, 32'h0, byte address of register 0; the interconnect passes addresses through unmodified.
- aclk  in  1  clock; all logic is on the rising edge.
- areset_n  in  1  reset, synchronous, active-low.
- araddr  in  ADDR_WIDTH  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- awaddr  in  ADDR_WIDTH  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte strobes.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response: OKAY or SLVERR.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- regs_o  out  NUM_REGS*DATA_WIDTH  live register contents; register i is at bits [i*32 +: 32].

## Operation
- Address decode:
  - off = addr - BASE_ADDR.
  - The address is in range iff addr >= BASE_ADDR and off < NUM_REGS*4.
  - Index = off[..:2]; addr[1:0] is ignored, so unaligned addresses hit the containing word.
- Write channel FSM, states W_IDLE and W_RESP:
  - W_IDLE: awready = !aw_held and wready = !w_held.
  - An AW handshake latches awaddr and sets aw_held. A W handshake latches wdata/wstrb and sets w_held.
  - AW and W may arrive in either order or in the same cycle.
  - When both are held (or complete in the current cycle), the write commits on that clock edge:
    - In range: for each byte b with wstrb[b]=1, reg[idx][8b+:8] <= wdata[8b+:8]; bresp = OKAY.
    - Out of range: no register changes; bresp = SLVERR.
  - The FSM then moves to W_RESP, clears both held flags and sets bvalid=1.
  - W_RESP: awready=wready=0. bvalid and bresp stay stable until bready=1, then W_IDLE with bvalid=0.
  - wstrb=0 is a legal no-op write with OKAY.
- Read channel FSM, states R_IDLE and R_DATA:
  - R_IDLE: arready=1.
  - On an AR handshake, rdata = reg[idx] (0 if out of range) and rresp is set; the FSM moves to R_DATA with rvalid=1.
  - R_DATA: arready=0. rdata, rresp and rvalid stay stable until rready=1, then R_IDLE.
- The read and write FSMs are fully independent and may be active concurrently.
- Read/write collision: an AR handshake in the same cycle as a write commit to the same register returns the pre-write value.
- regs_o shows the new value from the cycle after the commit.

## Timing
- Reset (areset_n=0 at a rising edge):
  - All registers = 0; both FSMs return to IDLE; held flags cleared.
  - rvalid=bvalid=0, rdata=0, rresp=bresp=0.
  - awready=wready=arready=0 while areset_n=0; they are 1 from the first cycle after reset is released.
- Reset mid-transaction drops the transaction: no register update, no response.
- Write latency: AW+W handshake in cycle N → bvalid=1 in cycle N+1.
  - With AW and W in separate cycles, latency counts from the later one.
- Read latency: AR handshake in cycle N → rvalid=1 in cycle N+1.
- Throughput:
  - One write per 2 cycles when bready is held 1.
  - One read per 2 cycles when rready is held 1.
  - No outstanding-transaction queueing; the next AR or AW is accepted only after the previous response handshake.
- Outputs are registered; there is no combinational path from inputs to any valid or ready output.

## Test plan
- Reset then read all 4 registers at 0x0/0x4/0x8/0xC → rdata=0, rresp=OKAY, rvalid exactly 1 cycle after each AR handshake.
- Write 0xDEADBEEF to 0x4 with wstrb=4'hF, AW and W in the same cycle → bvalid next cycle with OKAY; read 0x4 returns 0xDEADBEEF; regs_o[63:32]=0xDEADBEEF.
- Write 0x11223344 to 0x8 with wstrb=4'b0101 over prior value 0xAABBCCDD, W two cycles before AW → reg = 0xAA22CC44; bvalid 1 cycle after the AW handshake.
- BASE_ADDR=0x10: write to 0x20 and read 0x0C → bresp=SLVERR and rresp=SLVERR with rdata=0; no register changes.
- Hold bready=0 and rready=0 for 5 cycles → bvalid/rvalid, bresp/rresp and rdata stay stable; awready/wready/arready stay 0; a second AR is not accepted until rready.
- Same-cycle read and write commit to 0x0 (old 0x0, new 0x5) → read returns 0x0, a following read returns 0x5.
- Assert reset during W_RESP → bvalid=0 and all registers 0 the next cycle.
